// File: rtl/vermi_dma_pkg.sv
// Shared types for the Vermibus word-copy DMA: bus word/strobe types, the FSM state and alignment helpers.
package vermi_dma_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  strobe_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } vermi_dma_state_t;

  localparam strobe_t STROBE_READ  = 4'b0000;
  localparam strobe_t STROBE_WRITE = 4'b1111;
  localparam word_t   WORD_BYTES   = 32'd4;
  localparam word_t   ALIGN_MASK   = 32'hFFFF_FFFC;

  function automatic word_t word_align(input word_t address);
    return address & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/vermi_sync_fifo.sv
// Single-clock FIFO with a combinational head; push and pop may coincide, flush empties it in one cycle.
module vermi_sync_fifo
  import vermi_dma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  word_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Flush only rewinds the bookkeeping; stale storage is unreachable once count is zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/vermi_dma.sv
// Vermibus word-copy DMA master: reads up to BURST_WORDS words into a FIFO, writes them out, repeats until LENGTH words moved.
module vermi_dma
  import vermi_dma_pkg::*;
#(
  parameter int BURST_WORDS  = 4,
  parameter int LENGTH_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [31:0]             src_address,
  input  logic [31:0]             dst_address,
  input  logic [LENGTH_WIDTH-1:0] length,
  output logic                    busy,
  output logic                    done,
  output logic                    irq,
  input  logic                    irq_ack,
  output logic                    bus_valid,
  input  logic                    bus_ready,
  output logic [31:0]             bus_address,
  output logic [3:0]              bus_wstrobe,
  output logic [31:0]             bus_wdata,
  input  logic [31:0]             bus_rdata
);

  localparam int CW = $clog2(BURST_WORDS + 1);

  vermi_dma_state_t        state;
  word_t                   src_ptr;
  word_t                   dst_ptr;
  logic [LENGTH_WIDTH-1:0] remaining;
  logic [CW-1:0]           phase_count;
  logic                    abort_pending;

  logic  handshake;
  logic  in_transfer;
  logic  leave_on_abort;
  logic  fifo_push;
  logic  fifo_pop;
  logic  fifo_full;
  logic  fifo_empty;
  word_t fifo_head;

  assign handshake      = bus_valid && bus_ready;
  assign in_transfer    = (state == READ) || (state == WRITE);
  assign leave_on_abort = in_transfer && (abort || abort_pending) && (handshake || !bus_valid);
  assign fifo_push      = (state == READ) && handshake && !fifo_full;
  assign fifo_pop       = (state == WRITE) && handshake;
  assign busy           = (state != IDLE);
  assign bus_wdata      = ((state == WRITE) && !fifo_empty) ? fifo_head : '0;

  vermi_sync_fifo #(
    .DEPTH (BURST_WORDS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (leave_on_abort),
    .wdata (bus_rdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // phase_count tracks FIFO occupancy: counts up through a read phase, down through the matching write phase.
  // The bus request for the next word is loaded on the same edge as the handshake so transfers run back-to-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      src_ptr       <= '0;
      dst_ptr       <= '0;
      remaining     <= '0;
      phase_count   <= '0;
      abort_pending <= 1'b0;
      done          <= 1'b0;
      irq           <= 1'b0;
      bus_valid     <= 1'b0;
      bus_address   <= '0;
      bus_wstrobe   <= STROBE_READ;
    end else begin
      done <= 1'b0;
      if (irq_ack)              irq           <= 1'b0;
      if (in_transfer && abort) abort_pending <= 1'b1;

      if (leave_on_abort) begin
        state         <= IDLE;
        abort_pending <= 1'b0;
        phase_count   <= '0;
        bus_valid     <= 1'b0;
        bus_address   <= '0;
        bus_wstrobe   <= STROBE_READ;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (length != '0) begin
                state       <= READ;
                src_ptr     <= word_align(src_address);
                dst_ptr     <= word_align(dst_address);
                remaining   <= length;
                phase_count <= '0;
                bus_valid   <= 1'b1;
                bus_address <= word_align(src_address);
                bus_wstrobe <= STROBE_READ;
              end else begin
                state <= DONE;
                done  <= 1'b1;
                irq   <= 1'b1;
              end
            end
          end

          READ: begin
            if (handshake) begin
              src_ptr     <= src_ptr + WORD_BYTES;
              remaining   <= remaining - 1'b1;
              phase_count <= phase_count + 1'b1;
              if (phase_count == CW'(BURST_WORDS - 1) || remaining == LENGTH_WIDTH'(1)) begin
                state       <= WRITE;
                bus_address <= dst_ptr;
                bus_wstrobe <= STROBE_WRITE;
              end else begin
                bus_address <= src_ptr + WORD_BYTES;
              end
            end
          end

          WRITE: begin
            if (handshake) begin
              dst_ptr     <= dst_ptr + WORD_BYTES;
              phase_count <= phase_count - 1'b1;
              if (phase_count == CW'(1)) begin
                if (remaining == '0) begin
                  state       <= DONE;
                  done        <= 1'b1;
                  irq         <= 1'b1;
                  bus_valid   <= 1'b0;
                  bus_address <= '0;
                  bus_wstrobe <= STROBE_READ;
                end else begin
                  state       <= READ;
                  bus_address <= src_ptr;
                  bus_wstrobe <= STROBE_READ;
                end
              end else begin
                bus_address <= dst_ptr + WORD_BYTES;
              end
            end
          end

          DONE: begin
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vermi_dma.sv
// Directed bench for vermi_dma: short copy, multi-burst copy, ready stalls, zero length, abort, address wrap, async reset.
module tb_vermi_dma;

  localparam int          BURST = 4;
  localparam logic [31:0] KEY   = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        irq_ack;
  logic        bus_ready;
  logic [31:0] src_address;
  logic [31:0] dst_address;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        irq;
  logic        bus_valid;
  logic [31:0] bus_address;
  logic [3:0]  bus_wstrobe;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [3:0]  log_strb[$];
  int          valid_count = 0;
  int          idle_count  = 0;
  int          done_count  = 0;
  int          stall_left  = 0;
  logic        prev_stall  = 1'b0;
  logic [31:0] prev_addr   = '0;
  logic [31:0] prev_data   = '0;
  logic [3:0]  prev_strb   = '0;

  logic [31:0] t1_addr [6] = '{32'h100, 32'h104, 32'h108, 32'h200, 32'h204, 32'h208};
  logic [3:0]  t1_strb [6] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF};
  logic [31:0] t1_data [3] = '{32'hC0DE_0100, 32'hC0DE_0104, 32'hC0DE_0108};

  always #5 clk = ~clk;

  // Source memory model: each word's content is its address tagged with KEY.
  assign bus_rdata = (bus_valid && bus_wstrobe == 4'b0000) ? (bus_address ^ KEY) : 32'hDEAD_BEEF;

  vermi_dma #(
    .BURST_WORDS  (BURST),
    .LENGTH_WIDTH (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .src_address (src_address),
    .dst_address (dst_address),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .irq         (irq),
    .irq_ack     (irq_ack),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_address (bus_address),
    .bus_wstrobe (bus_wstrobe),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus monitor: logs every handshake, checks request stability across stalls, counts bus activity.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_addr", bus_address, prev_addr);
        checkOutput("stall_strobe", 32'(bus_wstrobe), 32'(prev_strb));
        checkOutput("stall_wdata", bus_wdata, prev_data);
      end
      prev_stall = bus_valid && !bus_ready;
      prev_addr  = bus_address;
      prev_strb  = bus_wstrobe;
      prev_data  = bus_wdata;
      if (bus_valid && bus_ready) begin
        log_addr.push_back(bus_address);
        log_strb.push_back(bus_wstrobe);
        log_data.push_back(bus_wdata);
      end
      if (bus_valid) valid_count++;
      if (busy && !bus_valid && !done) idle_count++;
      if (done) done_count++;
    end
  end

  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                               input bit stalls, output int done_cycle, output logic c1_busy,
                               output logic c1_valid);
    log_addr.delete();
    log_strb.delete();
    log_data.delete();
    valid_count = 0;
    idle_count  = 0;
    done_count  = 0;
    stall_left  = 0;
    src_address = src;
    dst_address = dst;
    length      = len;
    start       = 1'b1;
    bus_ready   = 1'b1;
    done_cycle  = -1;
    c1_busy     = 1'b0;
    c1_valid    = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      tick();
      start = 1'b0;
      if (n == 1) begin
        c1_busy  = busy;
        c1_valid = bus_valid;
      end
      if (done) begin
        done_cycle = n;
        break;
      end
      if (stalls) begin
        if (stall_left > 0) begin
          bus_ready = 1'b0;
          stall_left--;
        end else begin
          bus_ready  = 1'b1;
          stall_left = int'($urandom_range(0, 3));
        end
      end
    end
    bus_ready = 1'b1;
    tick();
  endtask

  // Rebuilds the expected R/W phase sequence from the burst size and compares it with the handshake log.
  task automatic checkLog(input string tag, input logic [31:0] src, input logic [31:0] dst, input int len);
    int idx = 0;
    int rd  = 0;
    int wr  = 0;
    int n;
    checkOutput({tag, "_handshakes"}, 32'(log_addr.size()), 32'(2 * len));
    if (log_addr.size() != 2 * len) return;
    while (wr < len) begin
      n = (len - rd < BURST) ? (len - rd) : BURST;
      for (int i = 0; i < n; i++) begin
        checkOutput({tag, "_raddr"}, log_addr[idx], src + 32'(4 * rd));
        checkOutput({tag, "_rstrobe"}, 32'(log_strb[idx]), 32'h0);
        idx++;
        rd++;
      end
      for (int i = 0; i < n; i++) begin
        checkOutput({tag, "_waddr"}, log_addr[idx], dst + 32'(4 * wr));
        checkOutput({tag, "_wstrobe"}, 32'(log_strb[idx]), 32'hF);
        checkOutput({tag, "_wdata"}, log_data[idx], (src + 32'(4 * wr)) ^ KEY);
        idx++;
        wr++;
      end
    end
  endtask

  initial begin
    int   dc;
    logic b1;
    logic v1;

    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    irq_ack     = 1'b0;
    bus_ready   = 1'b0;
    src_address = '0;
    dst_address = '0;
    length      = '0;
    tick();
    tick();

    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(bus_valid), 32'd0);
    checkOutput("rst_addr", bus_address, 32'd0);
    checkOutput("rst_strobe", 32'(bus_wstrobe), 32'd0);
    checkOutput("rst_wdata", bus_wdata, 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    tick();

    // Short copy smaller than one burst
    applyStimulus(32'h100, 32'h200, 16'd3, 1'b0, dc, b1, v1);
    checkOutput("t1_c1_busy", 32'(b1), 32'd1);
    checkOutput("t1_c1_valid", 32'(v1), 32'd1);
    checkOutput("t1_done_cycle", 32'(dc), 32'd7);
    checkOutput("t1_irq", 32'(irq), 32'd1);
    checkOutput("t1_handshakes", 32'(log_addr.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      checkOutput("t1_addr", log_addr[k], t1_addr[k]);
      checkOutput("t1_strobe", 32'(log_strb[k]), 32'(t1_strb[k]));
    end
    for (int k = 0; k < 3; k++) begin
      checkOutput("t1_wdata", log_data[k + 3], t1_data[k]);
    end

    // Ten words: R4 W4 R4 W4 R2 W2, back-to-back
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    applyStimulus(32'h1000, 32'h2000, 16'd10, 1'b0, dc, b1, v1);
    checkOutput("t2_done_cycle", 32'(dc), 32'd21);
    checkOutput("t2_idle_cycles", 32'(idle_count), 32'd0);
    checkOutput("t2_done_pulses", 32'(done_count), 32'd1);
    checkLog("t2", 32'h1000, 32'h2000, 10);

    // Random ready stalls
    applyStimulus(32'h3000, 32'h4000, 16'd6, 1'b1, dc, b1, v1);
    checkOutput("t3_completed", 32'(dc > 0), 32'd1);
    checkLog("t3", 32'h3000, 32'h4000, 6);

    // irq_ack alone clears, then zero-length transfer
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput("t4_irq_cleared", 32'(irq), 32'd0);
    applyStimulus(32'h5000, 32'h6000, 16'd0, 1'b0, dc, b1, v1);
    checkOutput("t4_done_cycle", 32'(dc), 32'd1);
    checkOutput("t4_valid_cycles", 32'(valid_count), 32'd0);
    checkOutput("t4_irq", 32'(irq), 32'd1);
    checkOutput("t4_done_pulses", 32'(done_count), 32'd1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput("t4_irq_ack", 32'(irq), 32'd0);

    // irq set and irq_ack on the same edge: set wins
    irq_ack     = 1'b1;
    length      = 16'd0;
    start       = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("t4_set_wins_done", 32'(done), 32'd1);
    checkOutput("t4_set_wins_irq", 32'(irq), 32'd1);
    tick();
    checkOutput("t4_ack_after", 32'(irq), 32'd0);
    irq_ack = 1'b0;
    tick();

    // Abort during the second, stalled write of a length-8 transfer
    log_addr.delete();
    log_strb.delete();
    log_data.delete();
    done_count  = 0;
    src_address = 32'h7000;
    dst_address = 32'h8000;
    length      = 16'd8;
    bus_ready   = 1'b1;
    start       = 1'b1;
    dc          = -1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      start = 1'b0;
      if (log_addr.size() == 5) begin
        dc = n;
        break;
      end
    end
    checkOutput("t5_reach_write2", 32'(dc), 32'd6);
    bus_ready = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t5_stalled_busy", 32'(busy), 32'd1);
    checkOutput("t5_stalled_valid", 32'(bus_valid), 32'd1);
    checkOutput("t5_stalled_addr", bus_address, 32'h8004);
    tick();
    bus_ready = 1'b1;
    tick();
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_valid", 32'(bus_valid), 32'd0);
    checkOutput("t5_done", 32'(done), 32'd0);
    checkOutput("t5_irq", 32'(irq), 32'd0);
    checkOutput("t5_handshakes", 32'(log_addr.size()), 32'd6);
    checkOutput("t5_last_addr", log_addr[5], 32'h8004);
    checkOutput("t5_last_data", log_data[5], 32'hC0DE_7004);
    bus_ready = 1'b0;
    tick();
    tick();
    checkOutput("t5_no_done", 32'(done_count), 32'd0);
    checkOutput("t5_still_idle", 32'(busy), 32'd0);
    applyStimulus(32'h9000, 32'hA000, 16'd2, 1'b0, dc, b1, v1);
    checkOutput("t5_restart_done_cycle", 32'(dc), 32'd5);
    checkLog("t5r", 32'h9000, 32'hA000, 2);

    // Source pointer wraps past the top of the address space
    applyStimulus(32'hFFFF_FFF8, 32'hB000, 16'd3, 1'b0, dc, b1, v1);
    checkOutput("t6_done_cycle", 32'(dc), 32'd7);
    checkOutput("t6_wrap_addr", log_addr[2], 32'h0000_0000);
    checkLog("t6", 32'hFFFF_FFF8, 32'hB000, 3);

    // Asynchronous reset in the middle of a read phase
    src_address = 32'hC000;
    dst_address = 32'hC800;
    length      = 16'd8;
    bus_ready   = 1'b1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("t6_pre_rst_valid", 32'(bus_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_arst_busy", 32'(busy), 32'd0);
    checkOutput("t6_arst_valid", 32'(bus_valid), 32'd0);
    checkOutput("t6_arst_addr", bus_address, 32'd0);
    checkOutput("t6_arst_strobe", 32'(bus_wstrobe), 32'd0);
    checkOutput("t6_arst_wdata", bus_wdata, 32'd0);
    checkOutput("t6_arst_done", 32'(done), 32'd0);
    checkOutput("t6_arst_irq", 32'(irq), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    applyStimulus(32'hD000, 32'hE000, 16'd1, 1'b0, dc, b1, v1);
    checkOutput("t6_after_rst_done_cycle", 32'(dc), 32'd3);
    checkLog("t6r", 32'hD000, 32'hE000, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
